// File: rtl/up_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one microprocessor bus among NREQ masters.
// One command at a time: accept, fixed-length access, one-cycle tagged completion.
module up_bus_arbiter #(
  parameter int unsigned NREQ          = 2,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic               up_clk,
  input  logic               up_rstn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*14-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  output logic [1:0]         rsp_id,
  output logic [31:0]        rsp_rdata,
  output logic               busy,
  output logic               up_csn,
  output logic               up_wbe,
  output logic [13:0]        up_addr,
  output logic [31:0]        up_data_out,
  output logic               up_data_oe,
  input  logic [31:0]        up_data_in
);

  localparam int unsigned MAX_REQ = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned AW      = 14;
  localparam int unsigned DW      = 32;

  typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   ptr, ptr_d;
  logic [IDX_W-1:0]   win, win_d;
  logic               cmd_wr, cmd_wr_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               up_csn_d, up_wbe_d, up_data_oe_d;
  logic [AW-1:0]      up_addr_d;
  logic [DW-1:0]      up_data_out_d;
  logic               rsp_valid_d, busy_d;
  logic [1:0]         rsp_id_d;
  logic [DW-1:0]      rsp_rdata_d;

  logic [MAX_REQ-1:0] valid_pad, wr_pad;
  logic [AW-1:0]      addr_pad  [MAX_REQ];
  logic [DW-1:0]      wdata_pad [MAX_REQ];
  logic               found;
  logic [IDX_W-1:0]   win_sel, cand;
  logic               accept_c;

  // Pad requester fields to MAX_REQ so the winner index always selects in range
  for (genvar i = 0; i < MAX_REQ; i++) begin : g_pad
    if (i < NREQ) begin : g_used
      assign valid_pad[i] = req_valid[i];
      assign wr_pad[i]    = req_wr[i];
      assign addr_pad[i]  = req_addr[AW*i +: AW];
      assign wdata_pad[i] = req_wdata[DW*i +: DW];
    end else begin : g_unused
      assign valid_pad[i] = 1'b0;
      assign wr_pad[i]    = 1'b0;
      assign addr_pad[i]  = '0;
      assign wdata_pad[i] = '0;
    end
  end

  // First asserted request searching from ptr upward, modulo NREQ
  always_comb begin
    found   = 1'b0;
    win_sel = ptr;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NREQ);
      if (!found && valid_pad[cand]) begin
        found   = 1'b1;
        win_sel = cand;
      end
    end
  end

  assign accept_c = (state == IDLE) && found;

  for (genvar i = 0; i < NREQ; i++) begin : g_ready
    assign req_ready[i] = accept_c && (win_sel == IDX_W'(i));
  end

  always_comb begin
    state_d       = state;
    ptr_d         = ptr;
    win_d         = win;
    cmd_wr_d      = cmd_wr;
    cnt_d         = cnt;
    up_csn_d      = 1'b1;
    up_wbe_d      = 1'b1;
    up_data_oe_d  = 1'b0;
    up_addr_d     = up_addr;
    up_data_out_d = up_data_out;
    rsp_valid_d   = 1'b0;
    rsp_id_d      = rsp_id;
    rsp_rdata_d   = rsp_rdata;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_d       = ACCESS;
          win_d         = win_sel;
          ptr_d         = (win_sel == IDX_W'(NREQ-1)) ? '0 : win_sel + 1'b1;
          cmd_wr_d      = wr_pad[win_sel];
          cnt_d         = '0;
          up_csn_d      = 1'b0;
          up_wbe_d      = ~wr_pad[win_sel];
          up_data_oe_d  = wr_pad[win_sel];
          up_addr_d     = addr_pad[win_sel];
          up_data_out_d = wr_pad[win_sel] ? wdata_pad[win_sel] : '0;
        end
      end
      ACCESS: begin
        if (cnt == CNT_W'(ACCESS_CYCLES-1)) begin
          state_d     = TURN;
          rsp_valid_d = 1'b1;
          rsp_id_d    = win;
          rsp_rdata_d = cmd_wr ? '0 : up_data_in;
        end else begin
          cnt_d        = cnt + 1'b1;
          up_csn_d     = 1'b0;
          up_wbe_d     = ~cmd_wr;
          up_data_oe_d = cmd_wr;
        end
      end
      TURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      state       <= IDLE;
      ptr         <= '0;
      win         <= '0;
      cmd_wr      <= 1'b0;
      cnt         <= '0;
      up_csn      <= 1'b1;
      up_wbe      <= 1'b1;
      up_data_oe  <= 1'b0;
      up_addr     <= '0;
      up_data_out <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_rdata   <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      win         <= win_d;
      cmd_wr      <= cmd_wr_d;
      cnt         <= cnt_d;
      up_csn      <= up_csn_d;
      up_wbe      <= up_wbe_d;
      up_data_oe  <= up_data_oe_d;
      up_addr     <= up_addr_d;
      up_data_out <= up_data_out_d;
      rsp_valid   <= rsp_valid_d;
      rsp_id      <= rsp_id_d;
      rsp_rdata   <= rsp_rdata_d;
      busy        <= busy_d;
    end
  end

endmodule
